// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner. It synchronizes and debounces the columns
// and emits one key code strobe per accepted press.
module keypad_scanner #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 20000
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    output logic [3:0] o_row,
    input  logic [3:0] i_col,
    output logic [3:0] o_keyCode,
    output logic       o_keyValid,
    output logic       o_keyHeld,
    output logic [1:0] o_state
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE_CNT);
    localparam logic [PW-1:0] LAST_PERIOD = PW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] LAST_STABLE = DW'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2
    } state_t;

    state_t        state;
    logic [1:0]    row_idx;
    logic [PW-1:0] period_cnt;
    logic [DW-1:0] stable_cnt;
    logic [DW-1:0] release_cnt;
    logic [3:0]    latched_col;
    logic [3:0]    col_meta;
    logic [3:0]    col_s;

    function automatic logic [3:0] row_drive(input logic [1:0] r);
        logic [3:0] onehot;
        onehot = 4'b0001 << r;
        return ~onehot;
    endfunction

    // Lowest-index low column wins when several columns are pressed on one row.
    function automatic logic [1:0] low_col(input logic [3:0] pat);
        if (!pat[0])      return 2'd0;
        else if (!pat[1]) return 2'd1;
        else if (!pat[2]) return 2'd2;
        else              return 2'd3;
    endfunction

    // Columns idle high, so the synchronizer resets to "no key".
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            col_meta <= 4'hF;
            col_s    <= 4'hF;
        end else begin
            col_meta <= i_col;
            col_s    <= col_meta;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= ST_SCAN;
            row_idx     <= 2'd0;
            o_row       <= 4'b1110;
            period_cnt  <= '0;
            stable_cnt  <= '0;
            release_cnt <= '0;
            latched_col <= 4'hF;
            o_keyCode   <= 4'd0;
            o_keyValid  <= 1'b0;
            o_keyHeld   <= 1'b0;
        end else begin
            o_keyValid <= 1'b0;
            case (state)
                ST_SCAN: begin
                    if (period_cnt == LAST_PERIOD) begin
                        period_cnt <= '0;
                        if (col_s != 4'hF) begin
                            // The sample cycle is the first of the stable run.
                            latched_col <= col_s;
                            stable_cnt  <= DW'(1);
                            state       <= ST_DEBOUNCE;
                        end else begin
                            row_idx <= row_idx + 2'd1;
                            o_row   <= row_drive(row_idx + 2'd1);
                        end
                    end else begin
                        period_cnt <= period_cnt + PW'(1);
                    end
                end

                ST_DEBOUNCE: begin
                    if (col_s != latched_col) begin
                        state      <= ST_SCAN;
                        stable_cnt <= '0;
                        period_cnt <= '0;
                        row_idx    <= row_idx + 2'd1;
                        o_row      <= row_drive(row_idx + 2'd1);
                    end else if (stable_cnt == LAST_STABLE) begin
                        state       <= ST_PRESSED;
                        stable_cnt  <= '0;
                        release_cnt <= '0;
                        o_keyCode   <= {row_idx, low_col(latched_col)};
                        o_keyValid  <= 1'b1;
                        o_keyHeld   <= 1'b1;
                    end else begin
                        stable_cnt <= stable_cnt + DW'(1);
                    end
                end

                ST_PRESSED: begin
                    if (col_s == 4'hF) begin
                        if (release_cnt == LAST_STABLE) begin
                            state       <= ST_SCAN;
                            release_cnt <= '0;
                            period_cnt  <= '0;
                            row_idx     <= 2'd0;
                            o_row       <= 4'b1110;
                            o_keyHeld   <= 1'b0;
                        end else begin
                            release_cnt <= release_cnt + DW'(1);
                        end
                    end else begin
                        release_cnt <= '0;
                    end
                end

                default: begin
                    state <= ST_SCAN;
                end
            endcase
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad model answers the row drive, and a
// timestamp-based reference model predicts row, hold, code and strobe timing.
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DC = 8;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] i_col = 4'hF;
    logic [3:0] o_row;
    logic [3:0] o_keyCode;
    logic       o_keyValid;
    logic       o_keyHeld;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC)) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .o_row      (o_row),
        .i_col      (i_col),
        .o_keyCode  (o_keyCode),
        .o_keyValid (o_keyValid),
        .o_keyHeld  (o_keyHeld),
        .o_state    (dbg_state)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int strobes = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, required %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [3:0] row_mask(input int r);
        logic [3:0] m;
        m = 4'b0001 << r;
        return ~m;
    endfunction

    // ---------------- physical keypad ----------------
    logic [15:0] keys = '0;
    logic [3:0]  cv;

    always @(negedge clk) begin
        #1;
        cv = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!o_row[r] && keys[r*4+c]) cv[c] = 1'b0;
        i_col = cv;
    end

    // ---------------- reference model ----------------
    // mode: 0 scanning, 1 qualifying a press, 2 key held.
    int         cyc = 0;
    int         mode = 0;
    int         t0 = 0;
    int         r0 = 0;
    int         tdet = 0;
    int         lrow = 0;
    int         rel = -1;
    int         exp_row = 0;
    logic [3:0] pat = 4'hF;
    logic [3:0] s1 = 4'hF;
    logic [3:0] s2 = 4'hF;
    logic [3:0] exp_code = 4'd0;
    logic       exp_held = 1'b0;
    logic [35:0] exp_q[$];

    task automatic model_reset();
        mode = 0; t0 = cyc; r0 = 0; rel = -1;
        s1 = 4'hF; s2 = 4'hF;
        exp_code = 4'd0; exp_held = 1'b0; exp_row = 0;
        exp_q.delete();
    endtask

    always @(negedge rst_n) model_reset();

    always @(posedge clk) begin
        int n;
        int lc;
        logic [3:0] cs;
        logic [31:0] due;
        if (!rst_n) begin
            cyc++;
            model_reset();
        end else begin
            n = cyc;
            cs = s2;
            case (mode)
                0: if ((n - t0) % SD == SD - 1 && cs != 4'hF) begin
                       mode = 1; tdet = n; pat = cs;
                       lrow = (r0 + (n - t0) / SD) % 4;
                   end
                1: if (cs != pat) begin
                       mode = 0; t0 = n + 1; r0 = (lrow + 1) % 4;
                   end else if (n - tdet + 1 == DC) begin
                       mode = 2; rel = -1; exp_held = 1'b1;
                       lc = 3;
                       for (int c = 3; c >= 0; c--) if (!pat[c]) lc = c;
                       exp_code = 4'(lrow * 4 + lc);
                       due = n + 1;
                       exp_q.push_back({due, exp_code});
                   end
                default: if (cs == 4'hF) begin
                       if (rel < 0) rel = n;
                       if (n - rel + 1 == DC) begin
                           mode = 0; t0 = n + 1; r0 = 0; exp_held = 1'b0;
                       end
                   end else begin
                       rel = -1;
                   end
            endcase
            s2 = s1;
            s1 = i_col;
            cyc = n + 1;
            exp_row = (mode == 0) ? (r0 + (cyc - t0) / SD) % 4 : lrow;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(posedge clk) begin
        logic [35:0] e;
        #2;
        check("row", o_row, row_mask(exp_row));
        check("held", o_keyHeld, exp_held);
        check("code", o_keyCode, exp_code);
        if (o_keyValid) begin
            strobes++;
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL strobe_unexpected at cycle %0d: code %0d, none required", cyc, o_keyCode);
            end else begin
                e = exp_q.pop_front();
                check("strobe_cycle", cyc, e[35:4]);
                check("strobe_code", o_keyCode, e[3:0]);
            end
        end else if (exp_q.size() != 0 && int'(exp_q[0][35:4]) <= cyc) begin
            e = exp_q.pop_front();
            n_cmp++; n_bad++;
            $display("FAIL strobe_missing at cycle %0d: got none, required code %0d at %0d", cyc, e[3:0], e[35:4]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_held(input logic v, input string nm);
        int k;
        k = 0;
        while (o_keyHeld !== v && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (o_keyHeld !== v) begin
            n_cmp++; n_bad++;
            $display("FAIL %s timeout: held %b, required %b", nm, o_keyHeld, v);
        end
    endtask

    task automatic wait_qualify(input string nm);
        int k;
        k = 0;
        while (mode != 1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (mode != 1) begin
            n_cmp++; n_bad++;
            $display("FAIL %s timeout: no press detection seen", nm);
        end
    endtask

    task automatic set_keys(input int r, input logic [3:0] m, input logic on);
        for (int c = 0; c < 4; c++) if (m[c]) keys[r*4+c] = on;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int s0;
        int r, nb, other;
        logic [3:0] m;

        // Reset and idle
        cycles(3);
        rst_n = 1'b1;
        s0 = strobes;
        cycles(64);
        check("idle_strobes", strobes - s0, 0);

        // Clean press of key 6
        s0 = strobes;
        keys[6] = 1'b1;
        wait_held(1'b1, "press6");
        cycles(30);
        keys[6] = 1'b0;
        wait_held(1'b0, "release6");
        cycles(10);
        check("press6_strobes", strobes - s0, 1);

        // Bounce on press of key 15
        s0 = strobes;
        keys[15] = 1'b1;
        wait_qualify("bounce15");
        cycles(1);
        keys[15] = 1'b0;
        cycles(1);
        keys[15] = 1'b1;
        wait_held(1'b1, "press15");
        cycles(20);
        keys[15] = 1'b0;
        wait_held(1'b0, "release15");
        cycles(10);
        check("press15_strobes", strobes - s0, 1);

        // Bounce on release of key 0
        s0 = strobes;
        keys[0] = 1'b1;
        wait_held(1'b1, "press0");
        cycles(10);
        keys[0] = 1'b0;
        cycles(5);
        keys[0] = 1'b1;
        cycles(1);
        keys[0] = 1'b0;
        wait_held(1'b0, "release0");
        cycles(10);
        check("press0_strobes", strobes - s0, 1);

        // Two columns on row 2, then a row-0 key while held
        s0 = strobes;
        keys[9] = 1'b1;
        keys[11] = 1'b1;
        wait_held(1'b1, "press9");
        keys[1] = 1'b1;
        cycles(20);
        keys = '0;
        wait_held(1'b0, "release9");
        cycles(10);
        check("press9_strobes", strobes - s0, 1);

        // Reset while key 5 is held
        keys[5] = 1'b1;
        wait_held(1'b1, "press5");
        cycles(5);
        rst_n = 1'b0;
        #1;
        check("rst_row", o_row, 4'b1110);
        check("rst_held", o_keyHeld, 1'b0);
        check("rst_valid", o_keyValid, 1'b0);
        check("rst_code", o_keyCode, 4'd0);
        cycles(3);
        rst_n = 1'b1;
        s0 = strobes;
        wait_held(1'b1, "repress5");
        cycles(10);
        check("repress5_strobes", strobes - s0, 1);
        keys[5] = 1'b0;
        wait_held(1'b0, "release5");
        cycles(10);

        // Randomized presses with bounce and cross-row keys
        for (int ep = 0; ep < 24; ep++) begin
            r = $urandom_range(0, 3);
            m = 4'($urandom_range(1, 15));
            set_keys(r, m, 1'b1);
            nb = $urandom_range(0, 3);
            repeat (nb) begin
                cycles($urandom_range(1, 6));
                set_keys(r, m, 1'b0);
                cycles($urandom_range(1, 3));
                set_keys(r, m, 1'b1);
            end
            cycles($urandom_range(30, 60));
            if ($urandom_range(0, 2) == 0) begin
                other = (r + 1 + $urandom_range(0, 2)) % 4;
                keys[other*4 + $urandom_range(0, 3)] = 1'b1;
                cycles(10);
                set_keys(other, 4'hF, 1'b0);
            end
            repeat (nb) begin
                set_keys(r, m, 1'b0);
                cycles($urandom_range(1, 5));
                set_keys(r, m, 1'b1);
                cycles($urandom_range(1, 2));
            end
            keys = '0;
            cycles($urandom_range(14, 40));
        end

        cycles(20);
        check("queue_empty", exp_q.size(), 0);
        check("final_held", o_keyHeld, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 active-low matrix keypad, synchronizes and debounces the column inputs, and delivers one key code per physical press as a single-cycle strobe. It is the input-side counterpart of the calculator/FND display path. Its decoded key codes feed the operand and operator capture logic that drives the calculator's `i_a`, `i_b` and `i_selOperator` inputs. All outputs are registered; one clock domain.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each row is driven during scanning; legal range ≥ 4.
- `DEBOUNCE_CNT`, default 20000: consecutive stable synchronized samples required to accept a press or a release; legal range ≥ 2.
- `i_clk`  input  1  system clock, all logic on rising edge.
- `i_reset_n`  input  1  asynchronous, active-low reset.
- `o_row`  output  4  row drive, active-low, exactly one bit low at all times.
- `i_col`  input  4  column sense, active-low (pulled up externally), asynchronous to `i_clk`.
- `o_keyCode`  output  4  last accepted key, `{row[1:0], col[1:0]}` = row*4 + col.
- `o_keyValid`  output  1  one-cycle strobe when `o_keyCode` is updated with a new press.
- `o_keyHeld`  output  1  high from acceptance of a press until acceptance of its release.

## Operation
- `i_col` passes through a 2-flop synchronizer; all decisions use the synchronized value `col_s`.
- States:
  - **SCAN.** A row counter drives `o_row`. A period counter runs from 0 to SCAN_DIV-1. `col_s` is sampled only when the period counter equals SCAN_DIV-1.
    - If any bit of `col_s` is low: latch the row and `col_s`, then go to DEBOUNCE. `o_row` stays frozen.
    - Otherwise: advance the row 0→1→2→3→0, wrapping, and restart the period counter.
  - **DEBOUNCE.** The row stays frozen. Each cycle, `col_s` is compared to the latched pattern.
    - Match: increment the stable counter.
    - Mismatch: abort with no strobe, return to SCAN at the next row, and clear the counters.
    - When the stable counter reaches DEBOUNCE_CNT: go to PRESSED, load `o_keyCode`, pulse `o_keyValid`, and set `o_keyHeld`.
  - **PRESSED.** The row stays frozen. The release counter counts consecutive cycles with `col_s` == 4'b1111; any low bit clears it. When it reaches DEBOUNCE_CNT: clear `o_keyHeld` and return to SCAN at row 0 with counters cleared.
- Multiple columns low in the latched pattern: the lowest-index low column is encoded. The whole 4-bit pattern must still stay stable through DEBOUNCE.
- Keys on other rows are ignored while in DEBOUNCE or PRESSED, so there is no rollover.
- `o_keyCode` holds its value until the next accepted press. A repeated press of the same key strobes again.

## Timing
- Reset values (asynchronous):
  - `o_row` = 4'b1110 (row 0);
  - `o_keyCode` = 0, `o_keyValid` = 0, `o_keyHeld` = 0;
  - state SCAN;
  - all counters and synchronizer flops cleared (synchronizer flops cleared to 1).
- Each row is driven for exactly SCAN_DIV cycles. Full scan period = 4*SCAN_DIV cycles.
- `i_col` reaches `col_s` 2 cycles after its change is registered. Sampling at the end of the row period guarantees at least SCAN_DIV-3 cycles of settle.
- Press latency: detection at sample cycle T; `o_keyValid` is high only at cycle T+DEBOUNCE_CNT, coincident with the new `o_keyCode` and the rising edge of `o_keyHeld`.
- Release latency: the first all-high `col_s` is at cycle R; `o_keyHeld` is low at cycle R+DEBOUNCE_CNT. Row 0 is driven and its period counter is 0 in that same cycle.
- `o_keyValid` is never high on two consecutive cycles. It is never asserted while `o_keyHeld` was already high.
- Reset asserted mid-press: outputs return to their reset values immediately. After release of reset, a still-held key is re-detected and strobed again as a new press.

## Test plan
For all scenarios below, SCAN_DIV=4 and DEBOUNCE_CNT=8.
1. **Reset and idle.** Hold `i_reset_n` low, release it, drive `i_col`=4'b1111 for 64 cycles.
   - Required: `o_row` cycles 1110→1101→1011→0111, each for 4 cycles, and wraps.
   - Required: `o_keyValid` and `o_keyHeld` stay 0 and `o_keyCode`=0 throughout.
2. **Clean press.** Pull col 2 low whenever row 1 is driven, hold for 40 cycles, then release.
   - Required: exactly one `o_keyValid` pulse, with `o_keyCode`=4'd6, 8 cycles after the sample cycle.
   - Required: `o_keyHeld` falls 8 cycles after `col_s` goes high, and scanning resumes at row 0.
3. **Bounce on press.** Press key 4'd15 (row 3, col 3), glitch col 3 high for 1 cycle after 3 stable cycles, then hold.
   - Required: no strobe from the first attempt; the press is detected on the next row-3 visit and a single strobe with code 15 follows.
4. **Bounce on release.** While key 4'd0 is held, toggle col 0 high for 5 cycles, low for 1 cycle, then high.
   - Required: `o_keyHeld` stays 1 through the glitch and falls 8 cycles after the final high.
   - Required: no second strobe.
5. **Multi-key.** Press row 2 with cols 1 and 3 simultaneously low.
   - Required: one strobe with code 4'd9.
   - Required: additionally pressing a key on row 0 while held produces no strobe.
6. **Reset mid-press.** While key 4'd5 is held, assert `i_reset_n` for 3 cycles, then deassert it with the key still down.
   - Required: outputs reset immediately, then exactly one new strobe with code 5 after re-detection.
